// File: rtl/bit_serializer.sv
// bit_serializer: one-entry buffered parallel-to-serial converter.
//
// A word is accepted into a holding register when load && ready. The FSM
// moves the held word into a shift register and streams it out one bit per
// clock, head bit first (MSB or LSB, set by MSB_FIRST). If another word is
// already held when the last bit goes out, it is reloaded on that same edge,
// so back-to-back words have no idle gap.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   load     request to accept data_in this cycle (honoured only when ready)
//   data_in  WIDTH-bit parallel word
//   ready    holding register empty; driven straight from a flop
//   out      serial bit; forced to 0 when not valid
//   valid    out carries a data bit (FSM in SHIFT)
//   done     one-cycle pulse on the last bit of each word
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             out,
  output logic             valid,
  output logic             done
);

  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic             hold_full, hold_full_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             head, last_bit;

  assign head     = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      sreg      <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      sreg      <= sreg_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    sreg_nxt      = sreg;
    cnt_nxt       = cnt;

    // Capture only when empty. A capture and a drain of hold can never
    // happen on the same edge: capture needs hold_full=0, drain needs 1.
    if (load && !hold_full) begin
      hold_nxt      = data_in;
      hold_full_nxt = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (hold_full) begin
          sreg_nxt      = hold;
          hold_full_nxt = 1'b0;
          cnt_nxt       = '0;
          state_nxt     = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          cnt_nxt = '0;
          if (hold_full) begin
            // Seamless reload: next word starts on the very next cycle.
            sreg_nxt      = hold;
            hold_full_nxt = 1'b0;
          end else begin
            sreg_nxt  = '0;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
          if (MSB_FIRST) sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
          else           sreg_nxt = {1'b0, sreg[WIDTH-1:1]};
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = !hold_full;
  assign valid = (state == SHIFT);
  assign out   = valid && head;
  assign done  = valid && last_bit;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share the
// same stimulus. Single words come from a vector table; back-to-back,
// ignored-load, async-reset and 101-detector chaining are hand sequences.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] data_in;
  logic       ready_m, out_m, valid_m, done_m;
  logic       ready_l, out_l, valid_l, done_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .ready(ready_m), .out(out_m), .valid(valid_m), .done(done_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .ready(ready_l), .out(out_l), .valid(valid_l), .done(done_l)
  );

  // Reference 101 detector (overlapping, Mealy) fed by the MSB-first stream.
  logic [1:0] hist;
  int         det_cnt;
  logic       det_clr;

  always @(posedge clk) begin
    if (det_clr) begin
      hist    <= 2'b00;
      det_cnt <= 0;
    end else begin
      if ({hist, out_m} == 3'b101) det_cnt <= det_cnt + 1;
      hist <= {hist[0], out_m};
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_m;   // expected MSB-first stream, first bit in [7]
    logic [7:0] exp_l;   // expected LSB-first stream, first bit in [7]
    string      name;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!(ready_m && ready_l) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk({name, " ready timeout"}, 0, 1);
  endtask

  task automatic send_word(input vec_t v);
    logic [7:0] sm, sl, dm, dl;
    int vc;
    wait_ready(v.name);
    data_in = v.data;
    load    = 1'b1;
    @(posedge clk); #1;              // E0: word captured into hold
    load = 1'b0;
    @(negedge clk);
    chk({v.name, " no bit before E1"}, {valid_m, valid_l}, 2'b00);
    @(posedge clk);                  // E1: hold -> shift register
    sm = '0; sl = '0; dm = '0; dl = '0; vc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sm = {sm[6:0], out_m};
      sl = {sl[6:0], out_l};
      dm = {dm[6:0], done_m};
      dl = {dl[6:0], done_l};
      vc += int'(valid_m && valid_l);
      @(posedge clk);
    end
    @(negedge clk);
    chk({v.name, " msb stream"}, sm, v.exp_m);
    chk({v.name, " lsb stream"}, sl, v.exp_l);
    chk({v.name, " valid count"}, vc, 8);
    chk({v.name, " msb done pos"}, dm, 8'h01);
    chk({v.name, " lsb done pos"}, dl, 8'h01);
    chk({v.name, " idle after"}, {valid_m, valid_l, out_m, out_l, done_m, done_l}, 6'b0);
  endtask

  initial begin
    logic [15:0] s16m, s16l, d16;
    logic [19:0] s20m, v20;
    int vc;

    vecs[0] = '{8'hA5, 8'b10100101, 8'b10100101, "A5"};
    vecs[1] = '{8'h01, 8'b00000001, 8'b10000000, "01"};
    vecs[2] = '{8'h80, 8'b10000000, 8'b00000001, "80"};
    vecs[3] = '{8'hC8, 8'b11001000, 8'b00010011, "C8"};
    vecs[4] = '{8'h3C, 8'b00111100, 8'b00111100, "3C"};
    vecs[5] = '{8'hFF, 8'b11111111, 8'b11111111, "FF"};

    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    det_clr = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset outputs", {valid_m, valid_l, out_m, out_l, done_m, done_l, ready_m, ready_l}, 8'b00000011);
    reset = 1'b0;

    // Single words from the table
    foreach (vecs[k]) send_word(vecs[k]);

    // Load held high: A5 then 3C, 16 contiguous bits
    wait_ready("b2b");
    data_in = 8'hA5; load = 1'b1;
    @(posedge clk); #1;              // E0 takes A5
    data_in = 8'h3C;
    @(posedge clk);                  // E1: A5 to shifter, load ignored (ready=0)
    s16m = '0; s16l = '0; d16 = '0; vc = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s16m = {s16m[14:0], out_m};
      s16l = {s16l[14:0], out_l};
      d16  = {d16[14:0], done_m};
      vc  += int'(valid_m);
      @(posedge clk); #1;
      if (i == 0) load = 1'b0;       // 3C was taken at E2
    end
    @(negedge clk);
    chk("b2b msb stream", s16m, 16'hA53C);
    chk("b2b lsb stream", s16l, 16'hA53C);
    chk("b2b valid contiguous", vc, 16);
    chk("b2b done pos", d16, 16'h0101);
    chk("b2b idle after", {valid_m, out_m}, 2'b00);

    // Load pulsed while hold is full must be ignored
    wait_ready("ign");
    data_in = 8'hA5; load = 1'b1;
    @(posedge clk); #1;              // E0
    load = 1'b0;
    @(posedge clk); #1;              // E1: A5 shifting, hold empty
    data_in = 8'h3C; load = 1'b1;
    s20m = '0; v20 = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s20m = {s20m[18:0], out_m};
      v20  = {v20[18:0], valid_m};
      @(posedge clk); #1;
      if (i == 0) begin
        chk("ign ready low while full", ready_m, 1'b0);
        data_in = 8'hFF;             // pulse while full
      end
      if (i == 1) load = 1'b0;
    end
    chk("ign stream", s20m, {16'hA53C, 4'h0});
    chk("ign valid", v20, 20'hFFFF0);

    // Async reset mid-word, with a second word held
    wait_ready("rst");
    data_in = 8'hA5; load = 1'b1;
    @(posedge clk); #1;              // E0
    load = 1'b0;
    @(posedge clk); #1;              // E1
    data_in = 8'h3C; load = 1'b1;
    @(posedge clk); #1;              // E2: 3C held
    load = 1'b0;
    @(posedge clk); #2;              // E3: third bit (1) on out
    chk("rst hold full before", ready_m, 1'b0);
    chk("rst bit before", {out_m, out_l}, 2'b11);
    #1 reset = 1'b1;
    #1 chk("rst async outputs", {valid_m, valid_l, out_m, out_l, done_m, done_l, ready_m, ready_l}, 8'b00000011);
    @(negedge clk);
    reset = 1'b0;
    vc = 0;
    repeat (12) begin
      @(negedge clk);
      vc += int'(valid_m || valid_l || out_m || out_l);
    end
    chk("rst no leftover bits", vc, 0);
    send_word(vecs[3]);

    // Chained to 101 detector: 10101000 gives two overlapping matches
    @(negedge clk);
    det_clr = 1'b0;
    send_word('{8'hA8, 8'b10101000, 8'b00010101, "A8"});
    repeat (2) @(negedge clk);
    chk("det 101 count", det_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
